// File: rtl/calc_display.sv
// Four-digit multiplexed seven-segment driver for the calculator accumulator.
// Shows a captured word as hex or signed magnitude, with leading-zero blanking, minus and zero indicators.
module calc_display #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic        clc,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        z,
  input  logic        load,
  input  logic        sgn,
  input  logic        blank_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic signed [15:0] shadow_p0;
  logic               zl_p0;
  logic [15:0]        cnt_p0;
  logic [1:0]         idx_p0;

  logic [3:0]         an_p1;
  logic [6:0]         seg_p1;
  logic               dp_p1;

  logic               neg;
  logic [15:0]        word;
  logic [3:0]         nib;
  logic               blank;
  logic [3:0]         an_d;
  logic [6:0]         seg_d;
  logic               dp_d;

  // Two's-complement negation wraps 0x8000 onto itself, which is the wanted magnitude.
  function automatic logic [15:0] magnitude(input logic signed [15:0] w);
    logic signed [15:0] m;
    m = -w;
    return m;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Stage p0: capture register, zero latch and digit scan state
  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      shadow_p0 <= '0;
      zl_p0     <= 1'b0;
      cnt_p0    <= '0;
      idx_p0    <= '0;
    end else begin
      if (load) begin
        shadow_p0 <= value;
        zl_p0     <= z;
      end
      if (cnt_p0 == REFRESH_DIV - 16'd1) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 2'd1;
      end else begin
        cnt_p0 <= cnt_p0 + 16'd1;
      end
    end
  end

  always_comb begin
    neg   = sgn & shadow_p0[15];
    word  = neg ? magnitude(shadow_p0) : shadow_p0;
    nib   = 4'h0;
    blank = 1'b0;
    case (idx_p0)
      2'd0: nib = word[3:0];
      2'd1: begin
        nib   = word[7:4];
        blank = blank_en & (word[15:4] == 12'h000);
      end
      2'd2: begin
        nib   = word[11:8];
        blank = blank_en & (word[15:8] == 8'h00);
      end
      default: begin
        nib   = word[15:12];
        blank = blank_en & (word[15:12] == 4'h0);
      end
    endcase
    // A blanked top digit still lights its enable so the minus point is visible.
    an_d = 4'b1111;
    if (!blank || (idx_p0 == 2'd3 && neg))
      an_d[idx_p0] = 1'b0;
    seg_d = blank ? 7'b1111111 : hex7(nib);
    dp_d  = ~((idx_p0 == 2'd3 && neg) || (idx_p0 == 2'd0 && zl_p0));
  end

  // Stage p1: registered display drive
  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= 4'b1111;
      seg_p1 <= 7'b1111111;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= an_d;
      seg_p1 <= seg_d;
      dp_p1  <= dp_d;
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = dp_p1;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display with a 4-cycle digit dwell.
module tb_calc_display;

  logic        clc;
  logic        rst_n;
  logic [15:0] value;
  logic        z;
  logic        load;
  logic        sgn;
  logic        blank_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int ntest = 0;
  int nfail = 0;
  int ncyc  = 0;

  calc_display #(.REFRESH_DIV(16'd4)) dut (
    .clc(clc), .rst_n(rst_n), .value(value), .z(z), .load(load),
    .sgn(sgn), .blank_en(blank_en), .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    clc = 1'b0;
    forever #5 clc = ~clc;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntest++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clc);
    #1;
    ncyc++;
  endtask

  // Digit shown after edge k is ((k-1)/4)%4 counting edges from reset release.
  // Expected tables are packed {digit3,digit2,digit1,digit0}.
  task automatic scan(input string tag, input logic [15:0] an4,
                      input logic [27:0] seg4, input logic [3:0] dp4);
    int d;
    for (int i = 0; i < 16; i++) begin
      step();
      d = ((ncyc - 1) / 4) % 4;
      chk($sformatf("%s_an_d%0d", tag, d), 16'(an), 16'(an4[4*d +: 4]));
      chk($sformatf("%s_seg_d%0d", tag, d), 16'(seg), 16'(seg4[7*d +: 7]));
      chk($sformatf("%s_dp_d%0d", tag, d), 16'(dp), 16'(dp4[d]));
    end
  endtask

  task automatic capture(input logic [15:0] v, input logic zz);
    value = v;
    z     = zz;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; value = '0; z = 1'b0; load = 1'b0; sgn = 1'b0; blank_en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clc);
    #1;
    chk("rst_an",  16'(an),  16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp",  16'(dp),  16'h1);

    @(negedge clc);
    rst_n = 1'b1;
    ncyc  = 0;
    step();
    chk("rel_an",  16'(an),  16'b1110);
    chk("rel_seg", 16'(seg), 16'b1000000);
    chk("rel_dp",  16'(dp),  16'h1);

    // Plain hex scan: F, A, 2, 1
    capture(16'h12AF, 1'b0);
    scan("hex", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
         {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111);

    // Leading-zero blanking
    blank_en = 1'b1;
    capture(16'h0030, 1'b0);
    scan("blank", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
         {7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000}, 4'b1111);

    // Signed -2: magnitude 2, minus point on blanked digit 3
    sgn = 1'b1;
    capture(16'hFFFE, 1'b0);
    scan("neg2", {4'b0111, 4'b1111, 4'b1111, 4'b1110},
         {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 4'b0111);

    // Most negative value keeps magnitude 0x8000
    capture(16'h8000, 1'b0);
    scan("neg8k", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
         {7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0111);

    // Zero flag point on digit 0
    sgn = 1'b0;
    blank_en = 1'b0;
    capture(16'h0000, 1'b1);
    scan("zf1", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
         {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1110);

    blank_en = 1'b1;
    capture(16'h0000, 1'b0);
    scan("zf0", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
         {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111);

    // Input changes without strobe must not reach the display
    value = 16'hBEEF;
    z     = 1'b1;
    scan("nold", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
         {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111);

    // Load on the same edge as a refresh wrap
    blank_en = 1'b0;
    for (int i = 0; i < 4 && (ncyc % 4) != 3; i++) step();
    capture(16'h4321, 1'b0);
    scan("wrap", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
         {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, 4'b1111);

    // Reset mid-dwell with a load pending
    step();
    step();
    #2;
    value = 16'hFFFF;
    z     = 1'b1;
    load  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_an",  16'(an),  16'hF);
    chk("mid_seg", 16'(seg), 16'h7F);
    chk("mid_dp",  16'(dp),  16'h1);
    @(posedge clc);
    #1;
    chk("hold_an", 16'(an), 16'hF);
    @(negedge clc);
    load  = 1'b0;
    rst_n = 1'b1;
    ncyc  = 0;
    step();
    chk("rel2_an",  16'(an),  16'b1110);
    chk("rel2_seg", 16'(seg), 16'b1000000);
    chk("rel2_dp",  16'(dp),  16'h1);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/calc_display.md
CALC_DISPLAY -- requirements
Module: calc_display

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, 16'd50000, clc cycles per digit dwell (legal range 2..65535).
REQ-002 SHALL have port: clc  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: value  input  16  accumulator word to display (driven from calc led bus).
REQ-005 SHALL have port: z  input  1  ALU zero flag, captured alongside value.
REQ-006 SHALL have port: load  input  1  capture strobe; samples value and z when high.
REQ-007 SHALL have port: sgn  input  1  1 = show value as signed magnitude, 0 = unsigned hex.
REQ-008 SHALL have port: blank_en  input  1  1 = suppress leading zero digits.
REQ-009 SHALL have port: an  output  4  digit enables, active-low, an[0] = rightmost digit.
REQ-010 SHALL have port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port: dp  output  1  decimal point, active-low.

Function
REQ-012 SHALL hold a 16-bit shadow register and 1-bit zero latch, both updated on the clc edge where load=1; held otherwise.
REQ-013 SHALL run a refresh counter 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-014 SHALL register an, seg, dp; outputs reflect shadow/index state from the previous edge (load sampled at edge N -> visible at edge N+1 on the active digit).
REQ-015 SHALL drive exactly one an bit low per cycle (index i -> an[i]=0), except when that digit is blanked (all an high).
REQ-016 SHALL show nibble display_word[4i+3:4i] on digit i.
REQ-017 SHALL form display_word = shadow when sgn=0 or shadow[15]=0; else two's-complement magnitude (0x8000 -> 0x8000).
REQ-018 SHALL decode hex: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 SHALL, when blank_en=1, blank digit i>0 if all nibbles of display_word at positions >=i are zero; digit 0 never blanked.
REQ-020 SHALL drive dp low on digit 3 when sgn=1 and shadow[15]=1 (minus indicator), even if digit 3 is blanked (an[3] then low, seg all high).
REQ-021 SHALL drive dp low on digit 0 when zero latch=1; dp high in all other cases.
REQ-022 SHALL treat sgn and blank_en as live (not captured); change takes effect next edge.
REQ-023 SHALL, on load coinciding with refresh wrap, apply both on the same edge (new value shown on the new digit next edge).

Reset
REQ-024 SHALL, while rst_n=0, force shadow=0, zero latch=0, counter=0, index=0, an=1111, seg=1111111, dp=1, independent of clc.
REQ-025 SHALL, on first edge after rst_n release, drive an=1110, seg=1000000 (digit 0 shows '0').
REQ-026 SHALL, on reset asserted mid-dwell or mid-load, discard captured value; no partial state survives.

Verification (REFRESH_DIV=4)
REQ-027 SHALL verify reset: rst_n low mid-cycle -> outputs at reset values immediately; release -> an=1110, seg=1000000 after one edge.
REQ-028 SHALL verify scan: load value=0x12AF, sgn=0, blank_en=0 -> digits 0..3 show F,A,2,1 (seg 0001110,0001000,0100100,1111001), each for 4 cycles, an cycling 1110,1101,1011,0111.
REQ-029 SHALL verify blanking: value=0x0030, blank_en=1 -> digits 2,3 an=1111; digit 1 shows 3, digit 0 shows 0.
REQ-030 SHALL verify signed: value=0xFFFE, sgn=1, blank_en=1 -> digit 0 shows 2, digits 1-2 blank, digit 3 an low with seg=1111111 and dp=0; value=0x8000 -> digit 3 shows 8, dp=0.
REQ-031 SHALL verify zero flag: load with value=0, z=1 -> digit 0 seg=1000000, dp=0; subsequent load z=0 -> dp=1.
REQ-032 SHALL verify load without strobe: value changes with load=0 -> display unchanged over full 16-cycle scan.
